// File: rtl/code_lock_fsm.sv
// code_lock_fsm: keypad code-entry controller. Compares BCD digits submitted
// on rising edges of `insere` against a CODE_LEN-digit code, tolerates up to
// MAX_ERRORS wrong digits, and drives a 7-segment display plus an error LED.
// Optional feature: define CODE_LOCK_TIMEOUT_EN to discard entry progress
// after TIMEOUT_CYCLES clock cycles without a submit.
module code_lock_fsm #(
  parameter int                    CODE_LEN       = 6,
  parameter logic [4*CODE_LEN-1:0] CODE           = 24'h589204,
  parameter int                    MAX_ERRORS     = 1,
  parameter int                    TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere,
  input  logic [3:0] numero,
  input  logic       limpa,
  output logic [1:0] estado,
  output logic [3:0] pos,
  output logic [2:0] erros,
  output logic [6:0] display,
  output logic       led
);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_SUCCESS = 2'd1,
    ST_PARTIAL = 2'd2,
    ST_FAIL    = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] last_digit;
  logic       insere_q;

  logic       submit;
  logic       digit_valid;
  logic [3:0] expected_digit;
  logic [3:0] pos_next;
  logic [3:0] err_next;
  logic       err_limit;
  logic [2:0] err_sat;
  logic       timeout_hit;

  // Seven-segment pattern (active-low, g in bit 0) for a BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000010;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign submit      = insere & ~insere_q;
  assign digit_valid = (numero <= 4'd9);
  assign pos_next    = pos + 4'd1;
  assign err_next    = {1'b0, erros} + 4'd1;
  assign err_limit   = (err_next > MAX_ERRORS[3:0]);
  assign err_sat     = err_next[3] ? 3'd7 : err_next[2:0];
  assign estado      = state;

  // Select the code digit expected at the current position (digit 0 is the MSB nibble).
  always_comb begin
    expected_digit = 4'd0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (pos == i[3:0]) expected_digit = CODE[4*(CODE_LEN-1-i) +: 4];
    end
  end

`ifdef CODE_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;
  logic          idle_running;

  assign idle_running = (state == ST_ENTRY) && ((pos != 4'd0) || (erros != 3'd0));
  assign timeout_hit  = idle_running && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: only runs while a partially entered code is pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (limpa || submit || timeout_hit || !idle_running) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Main controller: edge detect, digit comparison, error tracking and LED pulse.
  always_ff @(posedge clk) begin
    if (!reset || limpa) begin
      state      <= ST_ENTRY;
      pos        <= 4'd0;
      erros      <= 3'd0;
      last_digit <= 4'd0;
      led        <= 1'b0;
      insere_q   <= 1'b0;
    end else begin
      insere_q <= insere;
      led      <= 1'b0;
      if (submit) begin
        if (digit_valid && (state == ST_ENTRY)) begin
          last_digit <= numero;
          if (numero == expected_digit) begin
            pos <= pos_next;
            if (pos_next == CODE_LEN[3:0]) begin
              state <= (erros == 3'd0) ? ST_SUCCESS : ST_PARTIAL;
            end
          end else begin
            erros <= err_sat;
            led   <= 1'b1;
            if (err_limit) state <= ST_FAIL;
          end
        end
      end else if (timeout_hit) begin
        pos        <= 4'd0;
        erros      <= 3'd0;
        last_digit <= 4'd0;
      end
    end
  end

  // Display is decoded combinationally from the registered state.
  always_comb begin
    display = 7'b0000001;
    case (state)
      ST_ENTRY: begin
        if ((pos == 4'd0) && (erros == 3'd0)) display = 7'b0000001;
        else                                  display = seg7(last_digit);
      end
      ST_SUCCESS: display = 7'b0100100;
      ST_PARTIAL: display = 7'b0011000;
      ST_FAIL:    display = 7'b0111000;
      default:    display = 7'b0000001;
    endcase
  end

endmodule
